// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scanner.
// Anode and decimal-point levels are active-low at the pins.
package seg7_pkg;

  localparam int         DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic       DP_OFF = 1'b1;

  // All anodes high except the selected digit.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as a
// one-cycle tick before wrapping to 0.
module seg7_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scanner for a four-digit display: double-buffered digit
// storage swapped only at frame boundaries, optional leading-zero blanking.
import seg7_pkg::*;

module seg7_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lead,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  logic        tick;
  logic        boundary;
  logic [1:0]  idx;
  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic        pend_flag;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;
  logic [3:0]  digit_cur;
  logic [3:0]  zero_from;
  logic        blank_cur;

  seg7_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (idx == 2'd3);

  // load is a single-cycle strobe with no backpressure: every cycle it is
  // high the pending copy is overwritten; the scan picks it up at the next
  // frame boundary, or immediately if load lands on the boundary itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 2'd0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else begin
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (boundary) begin
        pend_flag <= 1'b0;
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pend_flag) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  // zero_from[i] is set when display digits i..3 are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (disp_val[15:12] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (disp_val[i*4 +: 4] == 4'd0);
    end
  end

  assign digit_cur = disp_val[{idx, 2'b00} +: 4];
  assign blank_cur = blank_lead && (idx != 2'd0) && zero_from[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      num        <= 4'd0;
      an         <= AN_OFF;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      num        <= digit_cur;
      an         <= blank_cur ? AN_OFF : an_sel(idx);
      dp         <= blank_cur ? DP_OFF : ~disp_dp[idx];
      frame_done <= boundary;
    end
  end

endmodule
